// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I memory arbiter slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = 4;

  // Owner encoding of the access currently in flight
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rv32i_mem_grant.sv
// Picks which requester owns the next memory access; data first, fetch protected from starvation.
// Latency: grant is combinational; run counter updates on the accepting edge.
// Backpressure: grant only names a winner; the caller gates acceptance with its own state.
module rv32i_mem_grant
  import rv32i_pkg::*;
#(
  parameter int MAX_DATA_RUN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_if_valid,
  input  logic i_d_valid,
  input  logic i_accept,
  input  logic i_owner,
  output logic o_grant
);

  localparam int              RUN_W   = 4;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  logic [RUN_W-1:0] r_run;

  // Data wins unless fetch is alone or data has used up its run against a waiting fetch
  always_comb begin
    o_grant = OWN_D;
    if (i_if_valid && !i_d_valid) begin
      o_grant = OWN_IF;
    end else if (i_if_valid && i_d_valid && (r_run == RUN_MAX)) begin
      o_grant = OWN_IF;
    end
  end

  // Count consecutive data grants that made a fetch wait; any uncontended grant restarts the run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= '0;
    end else if (i_accept) begin
      if ((i_owner == OWN_IF) || !i_if_valid) begin
        r_run <= '0;
      end else if (r_run != RUN_MAX) begin
        r_run <= r_run + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one access at a time.
// Latency: acceptance edge to response pulse is 2+MEM_LAT cycles (issue, MEM_LAT wait, response).
// Backpressure: ready only in IDLE/RESP for the granted port; a new request may be taken in RESP.
module rv32i_mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int MAX_DATA_RUN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_rsp_valid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [XLEN-1:0]   d_addr,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_rsp_valid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int CNT_W = 3;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_owner;
  logic               r_we;
  logic [XLEN-1:2]    r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [STRB_W-1:0]  r_wstrb;
  logic [XLEN-1:0]    r_if_rdata;
  logic [XLEN-1:0]    r_d_rdata;
  logic               w_grant;
  logic               w_slot_open;
  logic               w_accept;
  logic               w_capture;
  logic               w_unused;

  // Byte offset bits never reach the word-addressed memory
  assign w_unused = ^{if_addr[1:0], d_addr[1:0]};

  rv32i_mem_grant #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_grant (
    .clk        (clk),
    .reset      (reset),
    .i_if_valid (if_req_valid),
    .i_d_valid  (d_req_valid),
    .i_accept   (w_accept),
    .i_owner    (w_grant),
    .o_grant    (w_grant)
  );

  // Ready is suppressed while reset is held so nothing is accepted into a block being cleared
  assign w_slot_open  = reset && ((r_state == IDLE) || (r_state == RESP));
  assign if_req_ready = if_req_valid && (w_grant == OWN_IF) && w_slot_open;
  assign d_req_ready  = d_req_valid  && (w_grant == OWN_D)  && w_slot_open;
  assign w_accept     = if_req_ready || d_req_ready;
  assign w_capture    = (r_state == WAIT) && (r_cnt == CNT_W'(1));

  // State and wait-counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: issue one cycle, wait MEM_LAT cycles, respond one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = CNT_W'(MEM_LAT);
      end
      WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RESP;
        end
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      RESP: begin
        w_state_nxt = w_accept ? ISSUE : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Latch the accepted request; fetches carry no write fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_accept) begin
      r_owner <= w_grant;
      if (w_grant == OWN_D) begin
        r_addr  <= d_addr[XLEN-1:2];
        r_we    <= d_we;
        r_wdata <= d_wdata;
        r_wstrb <= d_wstrb;
      end else begin
        r_addr  <= if_addr[XLEN-1:2];
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_wstrb <= '0;
      end
    end
  end

  // Capture read data into the owner's holding register on the last wait edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (w_capture) begin
      if (r_owner == OWN_IF) begin
        r_if_rdata <= mem_rdata;
      end else begin
        r_d_rdata  <= mem_rdata;
      end
    end
  end

  // Memory strobes are live only during ISSUE; everything else drives zero
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (r_state == ISSUE) begin
      mem_en   = 1'b1;
      mem_we   = r_we;
      mem_addr = {r_addr, 2'b00};
      if (r_we) begin
        mem_wdata = r_wdata;
        mem_wstrb = r_wstrb;
      end
    end
  end

  assign if_rsp_valid = (r_state == RESP) && (r_owner == OWN_IF);
  assign d_rsp_valid  = (r_state == RESP) && (r_owner == OWN_D);
  assign if_rdata     = r_if_rdata;
  assign d_rdata      = r_d_rdata;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench: u_dut runs MEM_LAT=1, u_dut3 runs MEM_LAT=3 for the latency case.
// Memory models return the word exactly MEM_LAT cycles after mem_en, junk otherwise.
// Inputs driven on the falling edge, outputs sampled 1ns later.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        b_if_req_valid, b_if_req_ready, b_if_rsp_valid;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_d_req_valid, b_d_req_ready, b_d_we, b_d_rsp_valid;
  logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic [3:0]  b_d_wstrb;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wstrb;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [31:0] JUNK = 32'h0BAD0BAD;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.MEM_LAT(1), .MAX_DATA_RUN(2)) u_dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  rv32i_mem_arbiter #(.MEM_LAT(3), .MAX_DATA_RUN(2)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_addr(b_if_addr),
    .if_rsp_valid(b_if_rsp_valid), .if_rdata(b_if_rdata),
    .d_req_valid(b_d_req_valid), .d_req_ready(b_d_req_ready), .d_addr(b_d_addr),
    .d_we(b_d_we), .d_wdata(b_d_wdata), .d_wstrb(b_d_wstrb),
    .d_rsp_valid(b_d_rsp_valid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata)
  );

  // Read-only memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'hA5A5_0013;
      32'h0000_0008: mem_word = 32'h0081_2083;
      32'h0000_000C: mem_word = 32'h00C0_0113;
      32'h0000_0104: mem_word = 32'hDEAD_BEEF;
      default:       mem_word = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    pipe1 <= (mem_en && !mem_we) ? mem_word(mem_addr) : JUNK;
  end
  assign mem_rdata = pipe1;

  always @(posedge clk) begin
    pipe3[0] <= (b_mem_en && !b_mem_we) ? mem_word(b_mem_addr) : JUNK;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b_mem_rdata = pipe3[2];

  task automatic test_reset();
    reset = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h0;
    d_req_valid = 1'b1; d_addr = 32'h104; d_we = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
    b_if_req_valid = 1'b0; b_if_addr = 32'h0;
    b_d_req_valid = 1'b0; b_d_addr = 32'h0; b_d_we = 1'b0; b_d_wdata = 32'h0; b_d_wstrb = 4'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_total++; if ({if_req_ready, d_req_ready} !== 2'b00) $display("FAIL reset_ready c%0d got %b want 00", c, {if_req_ready, d_req_ready}); else n_pass++;
      n_total++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en c%0d got %b want 0", c, mem_en); else n_pass++;
      n_total++; if ({if_rsp_valid, d_rsp_valid} !== 2'b00) $display("FAIL reset_rsp c%0d got %b want 00", c, {if_rsp_valid, d_rsp_valid}); else n_pass++;
    end
    n_total++; if ({if_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata got %h want 0", {if_rdata, d_rdata}); else n_pass++;
    @(negedge clk); reset = 1'b1; #1;
    n_total++; if ({if_req_ready, d_req_ready} !== 2'b01) $display("FAIL release_ready got %b want 01", {if_req_ready, d_req_ready}); else n_pass++;
    @(negedge clk); if_req_valid = 1'b0; d_req_valid = 1'b0; #1;
    n_total++; if ({mem_en, mem_addr} !== {1'b1, 32'h104}) $display("FAIL release_issue got %b/%h want 1/00000104", mem_en, mem_addr); else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_load();
    int n_d = 0, n_i = 0;
    @(negedge clk); d_req_valid = 1'b1; d_addr = 32'h104; d_we = 1'b0; #1;
    n_total++; if (d_req_ready !== 1'b1) $display("FAIL load_ready got %b want 1", d_req_ready); else n_pass++;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk); if (n == 1) d_req_valid = 1'b0; #1;
      if (d_rsp_valid) n_d++;
      if (if_rsp_valid) n_i++;
      if (n == 1) begin
        n_total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h104}) $display("FAIL load_issue got en%b we%b %h want en1 we0 00000104", mem_en, mem_we, mem_addr); else n_pass++;
      end
      if (n == 3) begin
        n_total++; if ({d_rsp_valid, d_rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL load_rsp got %b/%h want 1/deadbeef", d_rsp_valid, d_rdata); else n_pass++;
      end
      if (n == 5) begin
        n_total++; if (d_rdata !== 32'hDEADBEEF) $display("FAIL load_hold got %h want deadbeef", d_rdata); else n_pass++;
      end
    end
    n_total++; if ({n_d, n_i} !== {32'd1, 32'd0}) $display("FAIL load_rsp_count got d%0d if%0d want d1 if0", n_d, n_i); else n_pass++;
  endtask

  task automatic test_store();
    int n_d = 0;
    @(negedge clk); d_req_valid = 1'b1; d_addr = 32'h13; d_we = 1'b1; d_wdata = 32'h11223344; d_wstrb = 4'b1000; #1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk); if (n == 1) begin d_req_valid = 1'b0; d_we = 1'b0; end #1;
      if (d_rsp_valid) n_d++;
      if (n == 1) begin
        n_total++; if ({mem_en, mem_we, mem_addr} !== {2'b11, 32'h10}) $display("FAIL store_issue got en%b we%b %h want en1 we1 00000010", mem_en, mem_we, mem_addr); else n_pass++;
        n_total++; if ({mem_wstrb, mem_wdata} !== {4'b1000, 32'h11223344}) $display("FAIL store_wfields got %b/%h want 1000/11223344", mem_wstrb, mem_wdata); else n_pass++;
      end
      if (n == 5) begin
        n_total++; if ({mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata} !== 70'h0) $display("FAIL idle_mem got en%b we%b %b %h %h want all 0", mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata); else n_pass++;
      end
    end
    n_total++; if (n_d !== 1) $display("FAIL store_rsp_count got %0d want 1", n_d); else n_pass++;
  endtask

  task automatic test_starvation();
    byte exp_ord [6];
    byte got_ord [6];
    int  g = 0, n_i = 0, n_d = 0;
    exp_ord = '{"D", "D", "I", "D", "D", "I"};
    got_ord = '{"-", "-", "-", "-", "-", "-"};
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if_req_valid = 1'b1; if_addr = 32'h0; d_req_valid = 1'b1; d_addr = 32'h104; d_we = 1'b0;
      end
      if (g >= 6) begin if_req_valid = 1'b0; d_req_valid = 1'b0; end
      #1;
      if (g < 6) begin
        if (d_req_ready) begin got_ord[g] = "D"; g++; end
        else if (if_req_ready) begin got_ord[g] = "I"; g++; end
      end
      if (if_rsp_valid) begin
        n_i++;
        n_total++; if (if_rdata !== 32'hA5A50013) $display("FAIL starve_if_rdata #%0d got %h want a5a50013", n_i, if_rdata); else n_pass++;
      end
      if (d_rsp_valid) n_d++;
    end
    for (int k = 0; k < 6; k++) begin
      n_total++; if (got_ord[k] !== exp_ord[k]) $display("FAIL starve_order[%0d] got %c want %c", k, got_ord[k], exp_ord[k]); else n_pass++;
    end
    n_total++; if ({n_i, n_d} !== {32'd2, 32'd4}) $display("FAIL starve_rsp_count got if%0d d%0d want if2 d4", n_i, n_d); else n_pass++;
  endtask

  task automatic test_latency();
    int first_n = -1, second_n = -1;
    logic [31:0] first_d = 32'h0, second_d = 32'h0;
    @(negedge clk); b_if_req_valid = 1'b1; b_if_addr = 32'h8; #1;
    n_total++; if (b_if_req_ready !== 1'b1) $display("FAIL lat_ready got %b want 1", b_if_req_ready); else n_pass++;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) b_if_addr = 32'hC;
      if (n == 6) b_if_req_valid = 1'b0;
      #1;
      if (n == 5) begin
        n_total++; if (b_if_req_ready !== 1'b1) $display("FAIL lat_b2b_ready got %b want 1", b_if_req_ready); else n_pass++;
      end
      if (b_if_rsp_valid) begin
        if (first_n < 0) begin first_n = n; first_d = b_if_rdata; end
        else if (second_n < 0) begin second_n = n; second_d = b_if_rdata; end
      end
    end
    n_total++; if (first_n !== 5) $display("FAIL lat_first_cycle got %0d want 5", first_n); else n_pass++;
    n_total++; if (first_d !== 32'h00812083) $display("FAIL lat_first_data got %h want 00812083", first_d); else n_pass++;
    n_total++; if (second_n !== 10) $display("FAIL lat_second_cycle got %0d want 10", second_n); else n_pass++;
    n_total++; if (second_d !== 32'h00C00113) $display("FAIL lat_second_data got %h want 00c00113", second_d); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int n_d = 0;
    @(negedge clk); d_req_valid = 1'b1; d_addr = 32'h104; d_we = 1'b0; #1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) d_req_valid = 1'b0;
      if (n == 2) reset = 1'b0;
      if (n == 4) reset = 1'b1;
      #1;
      if (d_rsp_valid) n_d++;
      if (n == 3) begin
        n_total++; if ({mem_en, d_rdata, if_rdata} !== 65'h0) $display("FAIL midrst_cleared got en%b d%h if%h want 0", mem_en, d_rdata, if_rdata); else n_pass++;
      end
    end
    n_total++; if (n_d !== 0) $display("FAIL midrst_no_rsp got %0d want 0", n_d); else n_pass++;
    @(negedge clk); if_req_valid = 1'b1; if_addr = 32'h8; #1;
    n_total++; if (if_req_ready !== 1'b1) $display("FAIL midrst_fetch_ready got %b want 1", if_req_ready); else n_pass++;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk); if (n == 1) if_req_valid = 1'b0; #1;
      if (d_rsp_valid) n_d++;
      if (n == 3) begin
        n_total++; if ({if_rsp_valid, if_rdata} !== {1'b1, 32'h00812083}) $display("FAIL midrst_fetch_rsp got %b/%h want 1/00812083", if_rsp_valid, if_rdata); else n_pass++;
      end
    end
    n_total++; if (n_d !== 0) $display("FAIL midrst_late_rsp got %0d want 0", n_d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_starvation();
    test_latency();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
